// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and defaults for the multi-port register file
package rf_pkg;
    localparam int RF_W = 8;
    localparam int RF_D = 3;

    localparam logic [RF_W-1:0] RF_PRELOAD [2**RF_D] =
        '{8'd0, 8'd0, 8'd0, 8'd0, 8'd64, 8'd54, 8'd62, 8'd63};

    typedef enum logic {SWEEP, RUN} rf_state_t;
endpackage

// File: rtl/rf_sweep_ctl.sv
// rtl/rf_sweep_ctl.sv - preload sweep sequencer: walks every address once, then runs
module rf_sweep_ctl
    import rf_pkg::*;
#(
    parameter int D = RF_D
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    output logic         ready,
    output logic         sweep_we,
    output logic [D-1:0] sweep_addr
);
    localparam logic [D:0] LAST = {1'b0, {D{1'b1}}};

    rf_state_t  state, state_nxt;
    logic [D:0] ptr, ptr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SWEEP;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        ready     = 1'b0;
        sweep_we  = 1'b0;
        case (state)
            SWEEP: begin
                sweep_we = 1'b1;
                ptr_nxt  = ptr + 1'b1;
                if (ptr == LAST) state_nxt = RUN;
            end
            RUN: begin
                ready = 1'b1;
                if (init) begin
                    state_nxt = SWEEP;
                    ptr_nxt   = '0;
                end
            end
            default: state_nxt = SWEEP;
        endcase
    end

    assign sweep_addr = ptr[D-1:0];
endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with prioritised writes, pending scoreboard
// and write-through bypass
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int         W       = RF_W,
    parameter int         D       = RF_D,
    parameter int         NRD     = 2,
    parameter bit         BYPASS  = 1'b1,
    parameter logic [W-1:0] PRELOAD [2**D] = RF_PRELOAD
) (
    input  logic                  Clk,
    input  logic                  ResetN,
    input  logic                  Init,
    input  logic                  WEnA,
    input  logic                  WEnB,
    input  logic [D-1:0]          WAddrA,
    input  logic [D-1:0]          WAddrB,
    input  logic [W-1:0]          WDataA,
    input  logic [W-1:0]          WDataB,
    input  logic                  ResvEn,
    input  logic [D-1:0]          ResvAddr,
    input  logic [NRD-1:0][D-1:0] RAddr,
    output logic [NRD-1:0][W-1:0] RData,
    output logic [NRD-1:0]        RPend,
    output logic                  Ready,
    output logic                  DropErr
);
    localparam int N = 2**D;

    logic [W-1:0] regs [N];
    logic [N-1:0] pend;
    logic         sweep_we;
    logic [D-1:0] sweep_addr;
    logic         wr_a, wr_b, resv;

    rf_sweep_ctl #(.D(D)) u_sweep (
        .clk        (Clk),
        .rst_n      (ResetN),
        .init       (Init),
        .ready      (Ready),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    // Port B loses silently when both ports hit the same address.
    assign wr_a = WEnA & Ready;
    assign wr_b = WEnB & Ready & ~(WEnA && (WAddrB == WAddrA));
    assign resv = ResvEn & Ready;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
            pend    <= '0;
            DropErr <= 1'b0;
        end else begin
            DropErr <= ~Ready & (WEnA | WEnB | ResvEn);
            if (sweep_we) begin
                regs[sweep_addr] <= PRELOAD[sweep_addr];
                pend[sweep_addr] <= 1'b0;
            end
            if (wr_b) begin
                regs[WAddrB] <= WDataB;
                pend[WAddrB] <= 1'b0;
            end
            if (wr_a) begin
                regs[WAddrA] <= WDataA;
                pend[WAddrA] <= 1'b0;
            end
            // Reservation is applied last so it wins over a same-cycle write.
            if (resv) pend[ResvAddr] <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            RData[i] = regs[RAddr[i]];
            RPend[i] = pend[RAddr[i]];
            if (BYPASS) begin
                if (wr_a && (WAddrA == RAddr[i])) begin
                    RData[i] = WDataA;
                    RPend[i] = resv && (ResvAddr == RAddr[i]);
                end else if (wr_b && (WAddrB == RAddr[i])) begin
                    RData[i] = WDataB;
                    RPend[i] = resv && (ResvAddr == RAddr[i]);
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp (bypass NRD=2 and array-only NRD=4)
module tb_reg_file_mp;
    localparam int W = 8;
    localparam int D = 3;
    localparam int N = 8;
    localparam logic [W-1:0] PRE [N] =
        '{8'd0, 8'd0, 8'd0, 8'd0, 8'd64, 8'd54, 8'd62, 8'd63};

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic         ResetN, Init, WEnA, WEnB, ResvEn;
    logic [D-1:0] WAddrA, WAddrB, ResvAddr;
    logic [W-1:0] WDataA, WDataB;
    logic [1:0][D-1:0] ra0;
    logic [1:0][W-1:0] rd0;
    logic [1:0]        rp0;
    logic              rdy0, de0;
    logic [3:0][D-1:0] ra1;
    logic [3:0][W-1:0] rd1;
    logic [3:0]        rp1;
    logic              rdy1, de1;

    reg_file_mp #(.W(W), .D(D), .NRD(2), .BYPASS(1'b1)) u0 (
        .Clk(Clk), .ResetN(ResetN), .Init(Init), .WEnA(WEnA), .WEnB(WEnB),
        .WAddrA(WAddrA), .WAddrB(WAddrB), .WDataA(WDataA), .WDataB(WDataB),
        .ResvEn(ResvEn), .ResvAddr(ResvAddr), .RAddr(ra0), .RData(rd0),
        .RPend(rp0), .Ready(rdy0), .DropErr(de0)
    );

    reg_file_mp #(.W(W), .D(D), .NRD(4), .BYPASS(1'b0)) u1 (
        .Clk(Clk), .ResetN(ResetN), .Init(Init), .WEnA(WEnA), .WEnB(WEnB),
        .WAddrA(WAddrA), .WAddrB(WAddrB), .WDataA(WDataA), .WDataB(WDataB),
        .ResvEn(ResvEn), .ResvAddr(ResvAddr), .RAddr(ra1), .RData(rd1),
        .RPend(rp1), .Ready(rdy1), .DropErr(de1)
    );

    typedef struct {
        logic              rdy;
        logic              de;
        logic [1:0][W-1:0] d0;
        logic [1:0]        p0;
        logic [3:0][W-1:0] d1;
        logic [3:0]        p1;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: register contents, pending flags, sweep progress
    logic [W-1:0] mreg [N];
    bit           mpend [N];
    bit           msweep;
    int           mptr;
    bit           mdrop;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mreg[i]  = '0;
            mpend[i] = 1'b0;
        end
        msweep = 1'b1;
        mptr   = 0;
        mdrop  = 1'b0;
    endfunction

    function automatic void model_edge();
        bit rdy;
        rdy = !msweep;
        if (!ResetN) begin
            model_reset();
            return;
        end
        mdrop = !rdy && (WEnA || WEnB || ResvEn);
        if (msweep) begin
            mreg[mptr]  = PRE[mptr];
            mpend[mptr] = 1'b0;
            mptr++;
            if (mptr == N) msweep = 1'b0;
        end else begin
            if (WEnB && !(WEnA && WAddrA == WAddrB)) begin
                mreg[WAddrB]  = WDataB;
                mpend[WAddrB] = 1'b0;
            end
            if (WEnA) begin
                mreg[WAddrA]  = WDataA;
                mpend[WAddrA] = 1'b0;
            end
            if (ResvEn) mpend[ResvAddr] = 1'b1;
            if (Init) begin
                msweep = 1'b1;
                mptr   = 0;
            end
        end
    endfunction

    function automatic exp_t model_read();
        exp_t         e;
        bit           rdy;
        logic [D-1:0] a;
        rdy   = !msweep;
        e.rdy = rdy;
        e.de  = mdrop;
        for (int i = 0; i < 2; i++) begin
            a = ra0[i];
            e.d0[i] = mreg[a];
            e.p0[i] = mpend[a];
            if (rdy && WEnA && WAddrA == a) begin
                e.d0[i] = WDataA;
                e.p0[i] = ResvEn && ResvAddr == a;
            end else if (rdy && WEnB && WAddrB == a) begin
                e.d0[i] = WDataB;
                e.p0[i] = ResvEn && ResvAddr == a;
            end
        end
        for (int i = 0; i < 4; i++) begin
            e.d1[i] = mreg[ra1[i]];
            e.p1[i] = mpend[ra1[i]];
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            while (expq.size() > 0) begin
                e = expq.pop_front();
                chk("ready0", 32'(rdy0), 32'(e.rdy));
                chk("ready1", 32'(rdy1), 32'(e.rdy));
                chk("droperr0", 32'(de0), 32'(e.de));
                chk("droperr1", 32'(de1), 32'(e.de));
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("u0_rdata%0d", i), 32'(rd0[i]), 32'(e.d0[i]));
                    chk($sformatf("u0_rpend%0d", i), 32'(rp0[i]), 32'(e.p0[i]));
                end
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("u1_rdata%0d", i), 32'(rd1[i]), 32'(e.d1[i]));
                    chk($sformatf("u1_rpend%0d", i), 32'(rp1[i]), 32'(e.p1[i]));
                end
            end
        end
    end

    // One clock of stimulus; fa >= 0 pins port 0 of both instances to that address.
    task automatic step(input bit rstn, input bit init,
                        input bit wea, input logic [D-1:0] aa, input logic [W-1:0] da,
                        input bit web, input logic [D-1:0] ab, input logic [W-1:0] db,
                        input bit resv, input logic [D-1:0] rv, input int fa);
        ResetN = rstn; Init = init;
        WEnA = wea; WAddrA = aa; WDataA = da;
        WEnB = web; WAddrB = ab; WDataB = db;
        ResvEn = resv; ResvAddr = rv;
        for (int i = 0; i < 2; i++) ra0[i] = D'($urandom_range(0, N-1));
        for (int i = 0; i < 4; i++) ra1[i] = D'($urandom_range(0, N-1));
        if (fa >= 0) begin
            ra0[0] = fa[D-1:0];
            ra1[0] = fa[D-1:0];
        end
        if (!rstn) model_reset();
        expq.push_back(model_read());
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int fa);
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, fa);
    endtask

    initial begin
        ResetN = 1'b0; Init = 1'b0; WEnA = 1'b0; WEnB = 1'b0; ResvEn = 1'b0;
        WAddrA = '0; WAddrB = '0; WDataA = '0; WDataB = '0; ResvAddr = '0;
        ra0 = '0; ra1 = '0;
        model_reset();
        #1;
        repeat (2) step(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 4);

        // Reset release: 8 sweep edges, then read every preloaded register
        for (int k = 0; k < 16; k++) idle(k % N);

        // Dual write to R2, A wins
        step(1'b1, 1'b0, 1'b1, 3'd2, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0, 3'd0, 2);
        idle(2);

        // Reservation, write clearing it, reservation beating a same-cycle write
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b1, 3'd3, 3);
        idle(3);
        step(1'b1, 1'b0, 1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3);
        idle(3);
        step(1'b1, 1'b0, 1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'd0, 1'b1, 3'd3, 3);
        idle(3);

        // Init after writing R5, with a dropped write during the sweep
        step(1'b1, 1'b0, 1'b1, 3'd5, 8'hFF, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 5);
        step(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 5);
        step(1'b1, 1'b0, 1'b1, 3'd1, 8'hC3, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1);
        for (int k = 0; k < 10; k++) idle(k < 9 ? 5 : 1);

        // Reset asserted at sweep edge 4 with stale data still in R6
        step(1'b1, 1'b0, 1'b1, 3'd6, 8'h99, 1'b1, 3'd7, 8'h77, 1'b0, 3'd0, 6);
        step(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 6);
        repeat (4) idle(6);
        repeat (2) step(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 6);
        for (int k = 0; k < 10; k++) idle(7);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            step(1'b1, ($urandom_range(0, 39) == 0),
                 1'($urandom), D'($urandom), W'($urandom),
                 1'($urandom), D'($urandom), W'($urandom),
                 ($urandom_range(0, 3) == 0), D'($urandom), -1);
        end

        repeat (2) @(negedge Clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
